// File: rtl/muldiv.sv
// muldiv: iterative RISC-V M-extension multiply/divide unit, 32-bit.
// Multi-cycle ops take 32 BUSY cycles, one bit per cycle. Divide by zero,
// signed overflow and compiled-out ops complete directly into DONE.
// Optional feature macro: MULDIV_MUL_EN (defined = multiply ops implemented;
// undefined = multiply datapath omitted, multiply ops flagged o_illegal).
module muldiv (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic        i_kill,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_illegal
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic        r_neg_q;   // negate quotient / product at the end
  logic        r_neg_r;   // negate remainder at the end
  logic [63:0] r_acc;     // div: {remainder, dividend/quotient}; mul: {high, multiplier/low}
  logic [31:0] r_b;       // divisor or multiplicand magnitude
  logic [31:0] r_result;
  logic        r_illegal;

  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_mul_off;
  logic        w_special;
  logic [31:0] w_special_res;
  logic        w_accept;
  logic        w_last;

  logic [32:0] w_trial;
  logic [63:0] w_div_nxt;
  logic [63:0] w_acc_nxt;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  // Operand decode: signedness, magnitudes and the single-cycle special cases.
  always_comb begin
    // Mul ops: rs1 signed except MULHU; rs2 signed for MUL/MULH. Div ops: signed if funct3[0]=0.
    w_a_signed = i_op[2] ? ~i_op[0] : (i_op[1:0] != 2'b11);
    w_b_signed = i_op[2] ? ~i_op[0] : ~i_op[1];
    w_a_neg    = w_a_signed & i_op1[31];
    w_b_neg    = w_b_signed & i_op2[31];
    w_a_mag    = w_a_neg ? (32'd0 - i_op1) : i_op1;
    w_b_mag    = w_b_neg ? (32'd0 - i_op2) : i_op2;
    w_div_zero = i_op[2] && (i_op2 == 32'd0);
    w_div_ovf  = i_op[2] && !i_op[0] && (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);
`ifdef MULDIV_MUL_EN
    w_mul_off  = 1'b0;
`else
    w_mul_off  = ~i_op[2];
`endif
    w_special  = w_div_zero | w_div_ovf | w_mul_off;
    w_special_res = 32'd0;
    if (w_mul_off) begin
      w_special_res = 32'd0;
    end else if (w_div_zero) begin
      w_special_res = i_op[1] ? i_op1 : 32'hFFFF_FFFF;
    end else if (w_div_ovf) begin
      w_special_res = i_op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  assign w_accept = i_valid && (r_state == StIdle) && !i_kill;
  assign w_last   = (r_cnt == 5'd31);

  // One iteration step: restoring shift-subtract, or shift-add when multiply is built in.
  always_comb begin
    w_trial   = {r_acc[63:32], r_acc[31]} - {1'b0, r_b};
    w_div_nxt = w_trial[32] ? {r_acc[62:0], 1'b0} : {w_trial[31:0], r_acc[30:0], 1'b1};
    w_acc_nxt = w_div_nxt;
`ifdef MULDIV_MUL_EN
    if (!r_op[2]) begin
      w_acc_nxt = {({1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0)), r_acc[31:1]};
    end
`endif
  end

  // Sign correction and result selection applied on the final iteration.
  always_comb begin
    w_quo   = r_neg_q ? (32'd0 - w_acc_nxt[31:0]) : w_acc_nxt[31:0];
    w_rem   = r_neg_r ? (32'd0 - w_acc_nxt[63:32]) : w_acc_nxt[63:32];
    w_final = 32'd0;
    unique case (r_op)
`ifdef MULDIV_MUL_EN
      OpMul:                     w_final = r_neg_q ? (32'd0 - w_acc_nxt[31:0]) : w_acc_nxt[31:0];
      OpMulh, OpMulhsu, OpMulhu: w_final = r_neg_q ? ((64'd0 - w_acc_nxt) >> 32) : w_acc_nxt[63:32];
`else
      OpMul, OpMulh, OpMulhsu, OpMulhu: w_final = 32'd0;
`endif
      OpDiv, OpDivu:             w_final = w_quo;
      OpRem, OpRemu:             w_final = w_rem;
      default:                   w_final = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; kill wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_nxt = w_special ? StDone : StBusy;
      end
      StBusy: begin
        if (i_kill)      w_state_nxt = StIdle;
        else if (w_last) w_state_nxt = StDone;
      end
      StDone: begin
        if (i_kill || i_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath: capture operands on accept, iterate in BUSY, latch result on the last step.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= 5'd0;
      r_op      <= 3'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_acc     <= 64'd0;
      r_b       <= 32'd0;
      r_result  <= 32'd0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= 5'd0;
      r_op      <= i_op;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_acc     <= i_op[2] ? {32'd0, w_a_mag} : {32'd0, w_b_mag};
      r_b       <= i_op[2] ? w_b_mag : w_a_mag;
      r_result  <= w_special_res;
      r_illegal <= w_mul_off;
    end else if ((r_state == StBusy) && !i_kill) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 5'd1;
      if (w_last) begin
        r_result  <= w_final;
        r_illegal <= 1'b0;
      end
    end
  end

  assign o_ready   = (r_state == StIdle);
  assign o_valid   = (r_state == StDone);
  assign o_result  = o_valid ? r_result : 32'd0;
  assign o_illegal = o_valid & r_illegal;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed and random checks of muldiv against an arithmetic reference model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        kill;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  muldiv u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid_in),
    .o_ready  (ready_out),
    .i_op     (op),
    .i_op1    (op1),
    .i_op2    (op2),
    .i_kill   (kill),
    .o_valid  (valid_out),
    .i_ready  (ready_in),
    .o_result (result),
    .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: RISC-V M semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    int     sx;
    int     sy;
    longint lx;
    longint ly;
    longint sp;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    lx = sx;
    ly = sy;
    r   = 32'd0;
    ill = 1'b0;
    lat = 33;
    if (!o[2]) begin
`ifdef MULDIV_MUL_EN
      case (o[1:0])
        2'b00: begin sp = lx * ly; r = sp[31:0]; end
        2'b01: begin sp = lx * ly; r = sp[63:32]; end
        2'b10: begin ly = {32'd0, y}; sp = lx * ly; r = sp[63:32]; end
        default: begin up = {32'd0, x} * {32'd0, y}; r = up[63:32]; end
      endcase
`else
      ill = 1'b1;
      lat = 1;
`endif
    end else if (y == 32'd0) begin
      lat = 1;
      r = o[1] ? x : 32'hFFFF_FFFF;
    end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      lat = 1;
      r = o[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      case (o[1:0])
        2'b00:   r = sx / sy;
        2'b01:   r = x / y;
        2'b10:   r = sx % sy;
        default: r = x % y;
      endcase
    end
  endfunction

  // Issue one op, check latency/result, apply hold cycles of backpressure, then retire it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold, input string tag);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          lat;
    model(o, x, y, er, ei, el);
    op = o; op1 = x; op2 = y; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    op = 3'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 1;
    while (!valid_out && lat < 40) begin
      chk({tag, "/zero_idle"}, result, 32'd0);
      tick();
      lat++;
    end
    chk({tag, "/valid"}, 32'(valid_out), 32'd1);
    chk({tag, "/latency"}, lat, el);
    chk({tag, "/result"}, result, er);
    chk({tag, "/illegal"}, 32'(illegal), 32'(ei));
    ready_in = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "/hold_valid"}, 32'(valid_out), 32'd1);
      chk({tag, "/hold_result"}, result, er);
      chk({tag, "/hold_ready"}, 32'(ready_out), 32'd0);
    end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk({tag, "/retire_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "/retire_ready"}, 32'(ready_out), 32'd1);
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (valid_out) seen++;
    end
    chk(tag, seen, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; op = 3'd0; op1 = 32'd0; op2 = 32'd0;
    kill = 1'b0; ready_in = 1'b0;
    tick();
    tick();
    chk("reset/ready", 32'(ready_out), 32'd1);
    chk("reset/valid", 32'(valid_out), 32'd0);
    chk("reset/result", result, 32'd0);
    chk("reset/illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1, "rem_m7_2");
    run_op(3'b101, 32'd100, 32'd7, 0, "divu_100_7");
    run_op(3'b111, 32'd100, 32'd7, 0, "remu_100_7");
    run_op(3'b100, 32'd5, 32'd0, 0, "div_5_0");
    run_op(3'b110, 32'd5, 32'd0, 0, "rem_5_0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 0, "mul_m2_3");
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 0, "mulh_m2_3");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
    run_op(3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, "mulhsu_m2");
    run_op(3'b101, 32'd100, 32'd7, 5, "backpressure");

    // Kill ten cycles into a divide.
    op = 3'b101; op1 = 32'd100; op2 = 32'd7; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy/ready", 32'(ready_out), 32'd1);
    chk("kill_busy/valid", 32'(valid_out), 32'd0);
    expect_quiet(40, "kill_busy/no_valid");

    // Kill in IDLE blocks acceptance.
    op = 3'b101; op1 = 32'd100; op2 = 32'd7; valid_in = 1'b1; kill = 1'b1;
    tick();
    valid_in = 1'b0; kill = 1'b0;
    chk("kill_idle/ready", 32'(ready_out), 32'd1);
    expect_quiet(3, "kill_idle/no_valid");

    // Reset pulsed mid-divide.
    op = 3'b100; op1 = 32'h1234_5678; op2 = 32'd3; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_reset/ready", 32'(ready_out), 32'd1);
    chk("mid_reset/valid", 32'(valid_out), 32'd0);
    chk("mid_reset/result", result, 32'd0);
    chk("mid_reset/illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    expect_quiet(40, "mid_reset/no_valid");
    run_op(3'b101, 32'd9, 32'd3, 0, "divu_9_3");

    for (int n = 0; n < 60; n++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             $urandom_range(0, 2), $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
